// File: rtl/cra_pipe_adder.sv
// Pipelined carry-ripple adder: {cout, s} = a + b + c0.
// The N-bit add is cut into K-bit ripple segments with one register stage per segment.
// The stream interface uses valid/ready, and the whole pipe advances on a single global enable.
module cra_pipe_adder #(
    parameter int unsigned N        = 16,
    parameter int unsigned K        = 4,
    parameter int unsigned CIN_MODE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int unsigned S = N / K;

    // Per-stage state. acc holds sum bits below the active segment and operand A bits from the
    // active segment upward. b holds operand B, and its bits below the active segment are zero.
    logic [N-1:0] acc_q [S];
    logic [N-1:0] acc_d [S];
    logic [N-1:0] b_q   [S];
    logic [N-1:0] b_d   [S];
    logic [S-1:0] c_q, c_d;
    logic [S-1:0] v_q, v_d;

    logic [N-1:0] merged [S];
    logic [S-1:0] carry;
    logic [K:0]   seg_sum;
    logic         c0;
    logic         en;

    // Select the carry-in source for stage 0.
    always_comb begin
        c0 = 1'b0;
        if (CIN_MODE == 2) begin
            c0 = cin;
        end else if (CIN_MODE == 1) begin
            c0 = 1'b1;
        end
    end

    // Ripple each stage's active segment and splice the sum into the carried-forward vector.
    always_comb begin
        merged  = '{default: '0};
        carry   = '0;
        seg_sum = '0;
        for (int i = 0; i < S; i++) begin
            seg_sum = {1'b0, acc_q[i][i*K +: K]} + {1'b0, b_q[i][i*K +: K]}
                      + {{K{1'b0}}, c_q[i]};
            // B below the active segment is always zero, so OR-ing it in leaves the sums intact.
            merged[i] = acc_q[i] | (b_q[i] & ~({N{1'b1}} << (i * K)));
            merged[i][i*K +: K] = seg_sum[K-1:0];
            carry[i] = seg_sum[K];
        end
    end

    // Global advance and stage-to-stage transfer. Bubbles move the valid bit but keep data.
    always_comb begin
        en    = !v_q[S-1] || out_ready;
        acc_d = acc_q;
        b_d   = b_q;
        c_d   = c_q;
        v_d   = v_q;
        if (en) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                acc_d[0] = a;
                b_d[0]   = b;
                c_d[0]   = c0;
            end
            for (int i = 1; i < S; i++) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    acc_d[i] = merged[i-1];
                    b_d[i]   = b_q[i-1];
                    b_d[i][(i-1)*K +: K] = '0;
                    c_d[i]   = carry[i-1];
                end
            end
        end
    end

    // Pipeline registers; reset clears every valid bit and all data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                acc_q[i] <= '0;
                b_q[i]   <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[S-1];
    assign s         = merged[S-1];
    assign cout      = carry[S-1];

endmodule

// File: doc/cra_pipe_adder.md
# cra_pipe_adder

Parametrised, pipelined carry-ripple adder computing {cout, s} = a + b + carry-in. The N-bit operands are split into K-bit ripple segments, with one register stage per segment, so throughput is one sum per clock at any width. It generalises the fixed 4-bit carry-ripple adders with three carry-in modes and a valid/ready stream interface. It sits on datapaths where a single-cycle N-bit ripple chain would miss timing.

## Interface
- N, 16: operand and sum width; must be a positive multiple of K.
- K, 4: segment width. S = N/K pipeline stages.
- CIN_MODE, 1: 0 = carry-in tied 0; 1 = carry-in tied 1; 2 = carry-in taken from port cin.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in, used only when CIN_MODE = 2; ignored otherwise.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- s  output  N  sum bits.
- cout  output  1  carry out of bit N-1.

## Operation
- Arithmetic: {cout, s} = a + b + c0, taken modulo 2^(N+1). c0 = 0, 1, or cin according to CIN_MODE. No overflow flag; operands are unsigned.
- Stage i (0..S-1) ripples bits [iK+K-1 : iK] using the carry registered by stage i-1. Stage 0 uses c0.
- Operand segments above stage i are carried forward in skew registers. Sum segments already produced are carried forward in deskew registers. All S segments of one beat therefore reach s together.
- Each stage holds a valid bit. Bubbles (no input beat) propagate as valid = 0 with unchanged data.
- Global advance: en = !out_valid || out_ready. in_ready = en, driven combinationally from out_valid and out_ready.
- On en = 1, every stage loads from its predecessor. Stage 0 loads {a, b, c0, in_valid}.
- On en = 0, all stages hold. s, cout and out_valid stay stable.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- When S = 1 (N = K), the block is a single registered ripple adder with the same handshake.
- No beats are dropped, duplicated or reordered.

## Timing
- Reset: while rst_n = 0, and asynchronously on its falling edge:
  - all valid bits clear and all data/carry registers clear;
  - out_valid = 0, s = 0, cout = 0;
  - in_ready = 1, since out_valid = 0.
- Reset release: the first beat can be accepted at the first rising edge after rst_n rises.
- Latency: a beat accepted at edge e appears on s/cout with out_valid = 1 from edge e+S-1, provided no stall occurs. For N=16, K=4 this is edge e+3. For S = 1 it is edge e.
- Throughput: one beat per cycle while out_ready = 1.
- Each cycle with out_valid = 1 and out_ready = 0 delays every in-flight beat by exactly one cycle.
- Simultaneous transfer in and out on a full pipe is legal: en = 1 and both transfers occur.
- Reset mid-operation discards all in-flight beats. No stale out_valid follows release.
- A change of cin is sampled only at the acceptance edge of the beat.

## Test plan
- Reset and basic add (N=16, K=4, CIN_MODE=1): release reset, apply a=16'hFFFF, b=16'h0000, in_valid=1 for one cycle, out_ready=1 -> in_ready=1 out of reset; at edge e+3, out_valid=1, s=16'h0000, cout=1; out_valid=0 the next cycle.
- Full carry ripple across all segments (CIN_MODE=2): a=16'h7FFF, b=16'h0000, cin=1 -> s=16'h8000, cout=0. Then a=16'hFFFF, b=16'hFFFF, cin=1 -> s=16'hFFFF, cout=1. Both appear on consecutive cycles, in order.
- Back-to-back stream: 100 random beats with in_valid held high and out_ready=1 -> one result per cycle after a 3-cycle fill. Every result equals a+b+c0 for all three CIN_MODE values (0, 1, 2).
- Backpressure: stream 8 beats while toggling out_ready randomly -> in_ready equals !out_valid||out_ready every cycle; s/cout hold while stalled; no beat is lost or duplicated; results are in order.
- Reset mid-flight: accept 3 beats, then pulse rst_n low for half a cycle asynchronously -> out_valid, s and cout go 0 immediately; no result for those beats ever appears; a new beat after release returns its correct sum at latency 4.
- Degenerate configuration N=K=8: a=8'hAA, b=8'h55, CIN_MODE=1 -> s=8'h00, cout=1, with out_valid at the acceptance edge (latency 1).
